pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It sits beside the decoder and the pipeline registers and produces every stall, bubble, flush and PC-redirect control in the core. It resolves load-use hazards on the decoder's rs1/rs2 addresses, redirects fetch on jumps and branches taken in EX, and freezes the pipeline while a multi-cycle data-memory access is outstanding. A watchdog raises a sticky error if memory never acknowledges.

## Interface
- MEM_TIMEOUT, 200: cycles a data-memory request may wait unacknowledged before an error is declared (1..255).
- TIMEOUT_W, 8: width of the wait counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1_addr  in  5  rs1 address from the decoder (0 when the instruction reads no rs1).
- id_rs2_addr  in  5  rs2 address from the decoder (0 when the instruction reads no rs2).
- ex_load  in  1  EX stage holds a load (its load code is not LOAD_NOPE).
- ex_wr_en  in  1  EX stage instruction writes rd.
- ex_rd_addr  in  5  EX stage destination register.
- ex_jmp_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- ex_jmp_target  in  32  redirect address for a taken jump.
- mem_req  in  1  MEM stage is issuing or holding a data-memory access.
- mem_ack  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold the IF/ID register.
- stall_id_ex  out  1  hold the ID/EX register.
- stall_ex_mem  out  1  hold the EX/MEM register.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- flush_if_id  out  1  load a NOP into IF/ID.
- pc_redirect  out  1  PC takes pc_target at the next edge.
- pc_target  out  32  redirect address.
- mem_timeout_err  out  1  sticky watchdog error.

## Operation
- FSM states: RUN, MEM_WAIT, REDIRECT, ERR. Reset state is RUN and the wait counter resets to 0.
- Outputs are Mealy, combinational from the state and the current inputs. Every output is 0 while rst_n=0 and in the first cycle after reset with idle inputs.
- When two conditions meet, memory wait wins over jump, and jump wins over load-use.
- Memory wait (RUN, mem_req=1, mem_ack=0):
  - Assert all four stall_* outputs.
  - No flush, bubble or redirect.
  - Next state MEM_WAIT, counter set to 1.
- MEM_WAIT, mem_ack=0:
  - All stalls stay asserted and the counter increments.
  - When the counter equals MEM_TIMEOUT, next state is ERR.
- MEM_WAIT, mem_ack=1:
  - The cycle is evaluated exactly as RUN with the memory condition false, so a jump or load-use hazard held during the wait is serviced now.
  - Counter clears.
- Jump (RUN, or MEM_WAIT with ack, ex_jmp_taken=1):
  - pc_redirect=1, pc_target=ex_jmp_target.
  - flush_if_id=1, bubble_id_ex=1.
  - Next state REDIRECT.
- REDIRECT:
  - flush_if_id=1 to discard the stale word returned by the synchronous instruction memory. No stalls.
  - Next state RUN.
  - A new mem_req without ack here is handled with RUN's memory-wait rule, which takes priority. Next state is then MEM_WAIT and flush_if_id remains asserted.
- Load-use: id_valid & ex_load & ex_wr_en & ex_rd_addr≠0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - stall_pc=1, stall_if_id=1, bubble_id_ex=1 for exactly one cycle. The load then leaves EX, so the condition clears.
  - The stall is not registered; the state stays RUN.
- Register x0 never creates a hazard.
- pc_target is 0 whenever pc_redirect=0.
- ERR:
  - All stalls asserted, mem_timeout_err=1.
  - The state is left only by rst_n=0; mem_ack is ignored.

## Timing
- Stall, bubble, flush and redirect are same-cycle responses to their inputs; the pipeline registers sample them at the next edge.
- mem_ack → stall deassertion is a combinational path within one cycle.
- Single-cycle memory (mem_req=1 with mem_ack=1 in the same cycle) causes zero stall cycles.
- An access acknowledged N cycles after it is first requested stalls exactly N cycles.
- Taken jump penalty is 2 cycles: the flush in the resolve cycle plus the REDIRECT cycle.
- Load-use penalty is 1 cycle.
- Timeout: ERR is entered at the edge ending the MEM_TIMEOUT-th consecutive unacknowledged cycle. mem_timeout_err is high from the following cycle.
- Reset asserted mid-operation, in any state, returns to RUN with all outputs 0 in the same cycle, combinationally on rst_n. The counter clears at the edge.

## Test plan
- Load-use hazard: ex_load=1, ex_wr_en=1, ex_rd_addr=5, id_rs2_addr=5, id_valid=1 → stall_pc, stall_if_id and bubble_id_ex high for 1 cycle. With ex_rd_addr=0 instead → no stall.
- Taken jump: ex_jmp_taken=1, ex_jmp_target=0x0000_0100 → the same cycle shows pc_redirect=1, pc_target=0x100, flush_if_id=1, bubble_id_ex=1. The next cycle shows flush_if_id=1 only. The cycle after that, all outputs are 0.
- Slow memory: mem_req=1 with mem_ack arriving 3 cycles later → all stalls high for exactly 3 cycles and low in the ack cycle.
- Simultaneous events: mem_req=1 without ack, plus ex_jmp_taken=1 → stalls only, no redirect. When ack arrives with the jump still held → redirect and flush in the ack cycle.
- Watchdog: MEM_TIMEOUT=4, mem_req=1, mem_ack never asserted → after 4 stalled cycles mem_timeout_err=1 and the stalls hold. A later mem_ack=1 has no effect. rst_n=0 for one edge → RUN with the error cleared.
- Load-use hazard during a memory wait: both conditions present → only the memory stall is applied. After ack, one load-use bubble follows if the hazard persists.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage RV32I core: load-use stalls,
// jump redirects/flushes, data-memory wait freeze and a memory-acknowledge watchdog.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        ex_load,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_jmp_taken,
  input  logic [31:0] ex_jmp_target,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        mem_timeout_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT, ERR} state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic                 load_use;
  logic                 mem_block;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign load_use = id_valid & ex_load & ex_wr_en & (ex_rd_addr != 5'd0) &
                    ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

  // Once waiting, only the acknowledge ends the freeze; mem_req is assumed held.
  assign mem_block = (state == MEM_WAIT) ? ~mem_ack : (mem_req & ~mem_ack);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    stall_pc        = 1'b0;
    stall_if_id     = 1'b0;
    stall_id_ex     = 1'b0;
    stall_ex_mem    = 1'b0;
    bubble_id_ex    = 1'b0;
    flush_if_id     = 1'b0;
    pc_redirect     = 1'b0;
    pc_target       = '0;
    mem_timeout_err = 1'b0;

    if (!rst_n) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (state == ERR) begin
      stall_pc        = 1'b1;
      stall_if_id     = 1'b1;
      stall_id_ex     = 1'b1;
      stall_ex_mem    = 1'b1;
      mem_timeout_err = 1'b1;
    end else if (mem_block) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      flush_if_id  = (state == REDIRECT);
      cnt_nxt      = (state == MEM_WAIT) ? cnt + TIMEOUT_W'(1) : TIMEOUT_W'(1);
      // cnt_nxt counts unacknowledged cycles including this one.
      state_nxt    = (cnt_nxt == TIMEOUT_VAL) ? ERR : MEM_WAIT;
    end else begin
      cnt_nxt     = '0;
      state_nxt   = RUN;
      flush_if_id = (state == REDIRECT);
      if (ex_jmp_taken) begin
        pc_redirect  = 1'b1;
        pc_target    = ex_jmp_target;
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        state_nxt    = REDIRECT;
      end else if (load_use) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end
  end

endmodule
